// File: rtl/seq_mag_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : seq_mag_cmp
//  Purpose  : Bit-serial magnitude comparator. Two WIDTH-bit operands are
//             compared MSB-first, one bit per clock. The result is reported
//             as registered greater / less / equal flags (S, I, E).
//             Optional two's-complement mode and early termination.
//  Ports    : clk, rst          - rising-edge clock, async active-high reset
//             start             - request a comparison (sampled in IDLE only)
//             g                 - cascade enable; 0 forces an all-zero result
//             signed_mode       - 1 treats operands as two's complement
//             a, b              - operands, latched when start is accepted
//             busy              - high while RUN or DONE
//             done              - one-cycle pulse, result valid
//             gt, lt, eq        - A > B, A < B, A == B (held until next start)
//             count             - bits examined in the last comparison
//  Revision : 1.0 - initial release
// ============================================================================
module seq_mag_cmp #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       g,
    input  logic                       signed_mode,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    output logic                       busy,
    output logic                       done,
    output logic                       gt,
    output logic                       lt,
    output logic                       eq,
    output logic [$clog2(WIDTH+1)-1:0] count
);

    // Index width is kept at least one bit so WIDTH = 1 still has a register.
    localparam int c_cnt_w = $clog2(WIDTH + 1);
    localparam int c_idx_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_idx_w-1:0] c_msb = c_idx_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic                 r_sm;
    logic [c_idx_w-1:0]   r_idx;
    logic                 r_gt;
    logic                 r_lt;
    logic                 r_eq;
    logic [c_cnt_w-1:0]   r_count;

    logic                 w_bit_diff;
    logic                 w_sign_bit;
    logic                 w_a_wins;
    logic                 w_decided;
    logic                 w_new_diff;

    // Bit under examination. On the sign bit in signed mode a set bit means
    // a negative value, so the sense of the comparison flips.
    always_comb begin
        w_bit_diff = r_a[r_idx] ^ r_b[r_idx];
        w_sign_bit = r_sm & (r_idx == c_msb);
        w_a_wins   = r_a[r_idx] ^ w_sign_bit;
        w_decided  = r_gt | r_lt;
        // Only the first differing bit may set the result.
        w_new_diff = w_bit_diff & ~w_decided;
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                // g is only needed to pick the path here, so it is consumed
                // directly at the accepting edge.
                if (start) begin
                    w_next = g ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (EARLY_EXIT && w_new_diff) begin
                    w_next = ST_DONE;
                end else if (r_idx == '0) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand, index and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sm    <= 1'b0;
            r_idx   <= '0;
            r_gt    <= 1'b0;
            r_lt    <= 1'b0;
            r_eq    <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_sm    <= signed_mode;
                        r_idx   <= c_msb;
                        r_gt    <= 1'b0;
                        r_lt    <= 1'b0;
                        r_eq    <= 1'b0;
                        r_count <= '0;
                    end
                end
                ST_RUN: begin
                    // count reaches at most WIDTH because RUN lasts at most
                    // WIDTH cycles, so it cannot wrap.
                    r_count <= r_count + c_cnt_w'(1);
                    if (w_new_diff) begin
                        r_gt <= w_a_wins;
                        r_lt <= ~w_a_wins;
                    end
                    if (w_next == ST_DONE) begin
                        // Equal only if no bit in the whole scan differed.
                        r_eq <= ~(w_decided | w_bit_diff);
                    end else begin
                        r_idx <= r_idx - c_idx_w'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy  = (r_state != ST_IDLE);
    assign done  = (r_state == ST_DONE);
    assign gt    = r_gt;
    assign lt    = r_lt;
    assign eq    = r_eq;
    assign count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_seq_mag_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_mag_cmp
//  Purpose  : Self-checking bench for seq_mag_cmp. Three instances cover
//             WIDTH=8/EARLY_EXIT=1, WIDTH=8/EARLY_EXIT=0 and WIDTH=1.
//             Results are compared with an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mag_cmp;

    logic       clk;
    logic       rst;
    logic [2:0] start_v;
    logic       g;
    logic       sm;
    logic [7:0] a8;
    logic [7:0] b8;
    logic [0:0] a1;
    logic [0:0] b1;

    logic [2:0] busy_v;
    logic [2:0] done_v;
    logic [2:0] gt_v;
    logic [2:0] lt_v;
    logic [2:0] eq_v;
    logic [3:0] cnt_e;
    logic [3:0] cnt_f;
    logic [0:0] cnt_1;

    int n_checks;
    int n_errors;
    int cur_sel;

    seq_mag_cmp #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_w8_early (
        .clk(clk), .rst(rst), .start(start_v[0]), .g(g), .signed_mode(sm),
        .a(a8), .b(b8), .busy(busy_v[0]), .done(done_v[0]),
        .gt(gt_v[0]), .lt(lt_v[0]), .eq(eq_v[0]), .count(cnt_e)
    );

    seq_mag_cmp #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_w8_full (
        .clk(clk), .rst(rst), .start(start_v[1]), .g(g), .signed_mode(sm),
        .a(a8), .b(b8), .busy(busy_v[1]), .done(done_v[1]),
        .gt(gt_v[1]), .lt(lt_v[1]), .eq(eq_v[1]), .count(cnt_f)
    );

    seq_mag_cmp #(.WIDTH(1), .EARLY_EXIT(1'b1)) u_w1 (
        .clk(clk), .rst(rst), .start(start_v[2]), .g(g), .signed_mode(sm),
        .a(a1), .b(b1), .busy(busy_v[2]), .done(done_v[2]),
        .gt(gt_v[2]), .lt(lt_v[2]), .eq(eq_v[2]), .count(cnt_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int cur_cnt(input int sel);
        case (sel)
            0:       return int'(cnt_e);
            1:       return int'(cnt_f);
            default: return int'(cnt_1);
        endcase
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: compare the operands as integers; the scan length is the
    // distance from the MSB to the first differing bit (inclusive) when
    // early exit is on, the whole width otherwise.
    task automatic model(input int w, input bit ee, input logic [7:0] av,
                         input logic [7:0] bv, input bit gg, input bit smv,
                         output int egt, output int elt, output int eeq,
                         output int ecnt);
        int va, vb, p;
        egt = 0; elt = 0; eeq = 0; ecnt = 0;
        if (gg) begin
            va = int'(av) & ((1 << w) - 1);
            vb = int'(bv) & ((1 << w) - 1);
            if (smv) begin
                if (va >= (1 << (w - 1))) va = va - (1 << w);
                if (vb >= (1 << (w - 1))) vb = vb - (1 << w);
            end
            egt  = (va > vb) ? 1 : 0;
            elt  = (va < vb) ? 1 : 0;
            eeq  = (va == vb) ? 1 : 0;
            ecnt = w;
            if (ee && (va != vb)) begin
                p = -1;
                for (int i = w - 1; i >= 0; i--) begin
                    if (p < 0 && av[i] != bv[i]) p = i;
                end
                ecnt = w - p;
            end
        end
    endtask

    // One comparison on instance sel. With perturb set, operands and mode
    // inputs are changed during RUN and a stray start is pulsed in the
    // third RUN cycle; neither may affect the result.
    task automatic run(input int sel, input logic [7:0] av, input logic [7:0] bv,
                       input bit gg, input bit smv, input bit perturb);
        int  w, lat, egt, elt, eeq, ecnt;
        bit  ee;
        w  = (sel == 2) ? 1 : 8;
        ee = (sel != 1);
        model(w, ee, av, bv, gg, smv, egt, elt, eeq, ecnt);
        cur_sel = sel;
        @(negedge clk);
        a8 = av; b8 = bv; a1 = av[0]; b1 = bv[0]; g = gg; sm = smv;
        start_v[sel] = 1'b1;
        @(posedge clk);
        #1;
        start_v[sel] = 1'b0;
        lat = 1;
        check("busy_after_start", int'(busy_v[sel]), 1);
        while (!done_v[sel] && lat < 40) begin
            if (perturb && lat == 2) begin
                a8 = 8'h00; b8 = 8'hFF; a1 = 1'b0; b1 = 1'b1; g = ~g; sm = ~sm;
            end
            start_v[sel] = (perturb && lat == 3);
            @(posedge clk);
            #1;
            lat++;
        end
        start_v[sel] = 1'b0;
        check("done_seen", int'(done_v[sel]), 1);
        check("latency", lat, gg ? ecnt + 1 : 1);
        check("gt", int'(gt_v[sel]), egt);
        check("lt", int'(lt_v[sel]), elt);
        check("eq", int'(eq_v[sel]), eeq);
        check("count", cur_cnt(sel), ecnt);
        @(posedge clk);
        #1;
        check("done_pulse_1cyc", int'(done_v[sel]), 0);
        check("idle_not_busy", int'(busy_v[sel]), 0);
        check("gt_held", int'(gt_v[sel]), egt);
        check("count_held", cur_cnt(sel), ecnt);
    endtask

    initial begin
        logic [7:0] ra, rb;
        int         sel;
        n_checks = 0; n_errors = 0; cur_sel = 0;
        rst = 1'b1; start_v = '0; g = 1'b1; sm = 1'b0;
        a8 = '0; b8 = '0; a1 = '0; b1 = '0;

        #12;
        for (int s = 0; s < 3; s++) begin
            check("rst_busy", int'(busy_v[s]), 0);
            check("rst_done", int'(done_v[s]), 0);
            check("rst_flags", int'({gt_v[s], lt_v[s], eq_v[s]}), 0);
            check("rst_count", cur_cnt(s), 0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Directed cases
        run(0, 8'h80, 8'h7F, 1'b1, 1'b0, 1'b0);
        run(0, 8'hA5, 8'hA4, 1'b1, 1'b0, 1'b0);
        run(0, 8'h80, 8'h7F, 1'b1, 1'b1, 1'b0);
        run(0, 8'hFF, 8'hFE, 1'b1, 1'b1, 1'b0);
        run(0, 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0);
        run(0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0);
        run(1, 8'h80, 8'h00, 1'b1, 1'b0, 1'b1);
        run(1, 8'h3C, 8'h3C, 1'b1, 1'b1, 1'b0);
        run(2, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
        run(2, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
        run(2, 8'h01, 8'h01, 1'b1, 1'b1, 1'b0);

        // Asynchronous reset in the 4th RUN cycle
        cur_sel = 1;
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h00; g = 1'b1; sm = 1'b0;
        start_v[1] = 1'b1;
        @(posedge clk);
        #1;
        start_v[1] = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_gt", int'(gt_v[1]), 1);
        check("pre_rst_count", cur_cnt(1), 3);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_busy", int'(busy_v[1]), 0);
        check("async_rst_done", int'(done_v[1]), 0);
        check("async_rst_flags", int'({gt_v[1], lt_v[1], eq_v[1]}), 0);
        check("async_rst_count", cur_cnt(1), 0);
        @(negedge clk);
        rst = 1'b0;
        run(1, 8'h12, 8'h34, 1'b1, 1'b0, 1'b0);

        // Randomized cases
        for (int i = 0; i < 60; i++) begin
            sel = i % 3;
            ra  = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (8'h01 << $urandom_range(0, 7));
                default: rb = 8'($urandom);
            endcase
            run(sel, ra, rb, ($urandom_range(0, 7) != 0), 1'($urandom),
                (sel == 1) && ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_mag_cmp.md
Name: seq_mag_cmp

Overview:
- Parametrised, bit-serial magnitude comparator for two WIDTH-bit operands.
- Compares MSB-first, one bit per clock, and reports greater / less / equal flags (S, I, E).
- Has a start/busy/done handshake, a cascade enable input `g`, a signed mode, and optional early termination.
- Successor to the combinational 1-bit-cell cascade; used wherever operands arrive wider than a combinational chain is acceptable.

Parameters:
- WIDTH, 8: operand width in bits; legal values are >= 1.
- EARLY_EXIT, 1: if 1, stop at the first differing bit; if 0, always scan all WIDTH bits.

Ports:
- clk  input  1  sole clock; rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a comparison; sampled only in IDLE.
- g  input  1  cascade enable, latched at start; 0 forces the all-zero result.
- signed_mode  input  1  latched at start; 1 treats operands as two's complement.
- a  input  WIDTH  operand A, latched at start.
- b  input  WIDTH  operand B, latched at start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result valid.
- gt  output  1  S: A > B.
- lt  output  1  I: A < B.
- eq  output  1  E: A == B.
- count  output  $clog2(WIDTH+1)  number of bits examined in the last comparison.

Behaviour:
- Reset (asynchronous, any state, including mid-RUN):
  - state = IDLE.
  - busy, done, gt, lt, eq, count = 0.
  - Internal operand registers and bit index cleared.
- States: IDLE, RUN, DONE.
- IDLE, start = 1 at a clock edge:
  - Latch a, b, g and signed_mode.
  - Clear gt, lt, eq and count.
  - Set index = WIDTH-1.
  - Next state is RUN if g = 1, otherwise DONE with the result left at 000 and count = 0.
- RUN, each cycle: examine bit `index` of the latched operands and increment count.
  - a_i = 1, b_i = 0 gives gt; a_i = 0, b_i = 1 gives lt.
  - Exception: when signed_mode = 1 and index = WIDTH-1 (sign bit), the sense is inverted (a_i = 1, b_i = 0 gives lt).
  - On the first differing bit, register gt or lt. No later bit may change a decided result.
  - If EARLY_EXIT = 1 and a difference is decided in this cycle, go to DONE.
  - Else if index = 0, go to DONE; eq = 1 if no difference was decided.
  - Else decrement index.
- DONE: lasts exactly one cycle with done = 1, then goes to IDLE.
- busy: high in RUN and DONE, low in IDLE.
- Results: gt, lt and eq are registered. They are held stable after done until the next accepted start, which clears them. Exactly one of the three is 1 after a g = 1 comparison; all three are 0 after a g = 0 comparison.
- Latency, with start sampled at edge k:
  - busy is high from k+1.
  - Full scan: RUN occupies WIDTH cycles; done is high in cycle k+WIDTH+1.
  - Early exit at bit p: RUN occupies WIDTH-p cycles.
  - g = 0: done is high in cycle k+1.
- start is ignored while busy (RUN or DONE); no queuing. Changes on a, b, g or signed_mode after latching have no effect on the comparison in progress.
- WIDTH = 1: the single bit is both MSB and LSB; the signed inversion applies.
- count never exceeds WIDTH and does not wrap.

Test Plan:
1. WIDTH=8, EARLY_EXIT=1, unsigned.
   - a=0x80, b=0x7F → gt=1, lt=0, eq=0, count=1, done pulses in cycle k+2.
   - a=0xA5, b=0xA4 → gt=1, count=8, done in cycle k+9.
2. Signed mode, a=0x80 (-128), b=0x7F (+127) → lt=1, count=1. Also a=0xFF (-1), b=0xFE (-2) → gt=1, count=8.
3. a=b=0x3C → eq=1, count=8.
   - Then start with g=0 and a=0xFF, b=0x00 → done in cycle k+1, gt=lt=eq=0, count=0.
4. EARLY_EXIT=0, a=0x80, b=0x00 → gt=1, count=8, done in cycle k+9.
   - Change a and b to 0x00/0xFF during RUN → result unchanged.
5. Pulse start again in the 3rd RUN cycle → ignored, result of the first comparison delivered.
   - Assert rst in the 4th RUN cycle → all outputs 0 immediately (asynchronously), state IDLE.
   - A fresh start after rst is released completes normally.
6. WIDTH=1, signed: a=1, b=0 → lt=1, count=1. Same operands unsigned → gt=1.
